// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
// Shared bus types for the core's instruction and data ports, the
// memory-side bus, and the arbiter state encoding.
// No ports; this file is imported by mem_bus_arbiter and its testbench.

package mem_bus_arbiter_pkg;

  // Instruction fetch port: the core only presents an address; fetches are reads.
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  // Data port: a non-zero strobe marks a write.
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  // Memory-side bus shared by both core ports.
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  // Size code for a 4-byte access, used for every instruction fetch.
  localparam logic [2:0] MSIZE4 = 3'b010;

endpackage

// File: rtl/mem_bus_arbiter_word_select.sv
// word_select
// Picks one half of a double-width data word.
// Ports:
//   data_in  in  [2*OUT_W-1:0]  full-width word from memory
//   sel_hi   in  1              1 selects the upper half, 0 the lower half
//   data_out out [OUT_W-1:0]    selected half

module word_select #(
  parameter int OUT_W = 32
) (
  input  logic [2*OUT_W-1:0] data_in,
  input  logic               sel_hi,
  output logic [OUT_W-1:0]   data_out
);

  assign data_out = sel_hi ? data_in[2*OUT_W-1:OUT_W] : data_in[OUT_W-1:0];

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares the single memory bus between the core's instruction port and
// data port, one outstanding transaction at a time. A request granted in
// IDLE is copied into a register latch that alone drives the memory bus
// until memory answers with ready. Simultaneous requests are resolved
// round-robin against the port served last.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high
//   ireq   in   instruction fetch request
//   iresp  out  instruction response (addr_ok, data_ok, 32-bit data)
//   dreq   in   data request
//   dresp  out  data response (addr_ok, data_ok, 64-bit data)
//   creq   out  memory bus request, driven from the latch
//   cresp  in   memory bus response (ready, data)
// IDATA_W sets the fetch word width; the ibus response struct carries a
// 32-bit word, so the default of 32 is the only width that fits it.

module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int IDATA_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);

  arb_state_t state_q, state_d;
  logic       last_d_q, last_d_d;
  cbus_req_t  lat_q, lat_d;
  logic       mis_q, mis_d;

  logic grant_i, grant_d;
  logic i_misaligned;
  logic [IDATA_W-1:0] i_word;

  // Fetch word taken from the half of the memory word chosen by addr[2].
  word_select #(
    .OUT_W(IDATA_W)
  ) u_word_select (
    .data_in  (cresp.data),
    .sel_hi   (lat_q.addr[2]),
    .data_out (i_word)
  );

  assign i_misaligned = (ireq.addr[1:0] != 2'b00);

  // Grant decision and next-state logic. The data port wins a conflict
  // unless it was the port served last. A misaligned fetch is granted but
  // never put on the memory bus; it completes with zero data one cycle later.
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    lat_d    = lat_q;
    mis_d    = mis_q;
    grant_i  = 1'b0;
    grant_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dreq.valid && (!ireq.valid || !last_d_q)) begin
          grant_d = 1'b1;
        end else if (ireq.valid) begin
          grant_i = 1'b1;
        end

        if (grant_d) begin
          lat_d          = '0;
          lat_d.valid    = 1'b1;
          lat_d.is_write = |dreq.strobe;
          lat_d.size     = dreq.size;
          lat_d.addr     = dreq.addr;
          lat_d.strobe   = dreq.strobe;
          lat_d.data     = dreq.data;
          mis_d          = 1'b0;
          state_d        = BUSY_D;
        end else if (grant_i) begin
          lat_d = '0;
          if (!i_misaligned) begin
            lat_d.valid = 1'b1;
            lat_d.size  = MSIZE4;
            lat_d.addr  = ireq.addr;
          end
          mis_d   = i_misaligned;
          state_d = BUSY_I;
        end
      end

      BUSY_I: begin
        if (mis_q || cresp.ready) begin
          lat_d    = '0;
          mis_d    = 1'b0;
          last_d_d = 1'b0;
          state_d  = IDLE;
        end
      end

      BUSY_D: begin
        if (cresp.ready) begin
          lat_d    = '0;
          last_d_d = 1'b1;
          state_d  = IDLE;
        end
      end

      default: begin
        lat_d   = '0;
        mis_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Core-facing responses. Handshakes are held low while reset is asserted
  // so that nothing is acknowledged in a cycle whose capture reset discards.
  // data_ok is dropped when the requester has withdrawn valid by the time
  // memory answers, so an abandoned transaction completes silently.
  always_comb begin
    iresp = '0;
    dresp = '0;

    iresp.addr_ok = grant_i && !reset;
    dresp.addr_ok = grant_d && !reset;

    if (!reset && (state_q == BUSY_I)) begin
      if (mis_q) begin
        iresp.data_ok = 1'b1;
      end else if (cresp.ready && ireq.valid) begin
        iresp.data_ok = 1'b1;
        iresp.data    = i_word;
      end
    end

    if (!reset && (state_q == BUSY_D) && cresp.ready && dreq.valid) begin
      dresp.data_ok = 1'b1;
      dresp.data    = cresp.data;
    end
  end

  // The memory bus sees only the latch, so requester changes after the
  // grant never reach it.
  assign creq = lat_q;

  // State, round-robin history and request latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      lat_q    <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      lat_q    <= lat_d;
      mis_q    <= mis_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Drives both core ports and the memory response, predicts every handshake
// from a transaction-level model of the arbitration rules, and compares
// through expectation queues drained by an independent monitor.

module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic       clk;
  logic       reset;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  mem_bus_arbiter #(
    .IDATA_W(32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq),
    .iresp (iresp),
    .dreq  (dreq),
    .dresp (dresp),
    .creq  (creq),
    .cresp (cresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int port;
    int cyc;
  } grant_t;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [63:0] addr;
    logic        is_write;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
    int          cyc;
  } cbus_t;

  grant_t q_grant[$];
  resp_t  q_iresp[$];
  resp_t  q_dresp[$];
  cbus_t  q_cbus[$];
  int     q_cend[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Transaction-level view of the arbiter: is a transaction outstanding,
  // which port owns it, is it a fetch that never goes to memory, and
  // which port was served last.
  bit          m_busy   = 0;
  bit          m_owner_d = 0;
  bit          m_mis    = 0;
  bit          m_last_d = 0;
  logic [63:0] m_iaddr  = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one cycle of inputs and updates the model with what that cycle
  // must produce.
  task automatic applyStimulus(input bit rst, input bit iv, input logic [63:0] ia,
                               input bit dv, input logic [63:0] da, input logic [2:0] ds,
                               input logic [7:0] dst, input logic [63:0] dd,
                               input bit rdy, input logic [63:0] rd);
    int winner;
    @(posedge clk);
    #1;
    cyc++;
    reset       = rst;
    ireq.valid  = iv;
    ireq.addr   = ia;
    dreq.valid  = dv;
    dreq.addr   = da;
    dreq.size   = ds;
    dreq.strobe = dst;
    dreq.data   = dd;
    cresp.ready = rdy;
    cresp.data  = rd;

    if (rst) begin
      if (m_busy && !m_mis) q_cend.push_back(cyc + 1);
      m_busy   = 0;
      m_mis    = 0;
      m_last_d = 0;
    end else if (!m_busy) begin
      winner = -1;
      if (dv && iv) winner = m_last_d ? 0 : 1;
      else if (dv)  winner = 1;
      else if (iv)  winner = 0;
      if (winner == 1) begin
        q_grant.push_back('{1, cyc});
        q_cbus.push_back('{da, (dst != 8'd0), ds, dst, dd, cyc + 1});
        m_busy    = 1;
        m_owner_d = 1;
      end else if (winner == 0) begin
        q_grant.push_back('{0, cyc});
        m_busy    = 1;
        m_owner_d = 0;
        m_iaddr   = ia;
        if (ia[1:0] != 2'b00) m_mis = 1;
        else q_cbus.push_back('{ia, 1'b0, 3'b010, 8'd0, 64'd0, cyc + 1});
      end
    end else if (m_mis) begin
      q_iresp.push_back('{64'd0, cyc});
      m_busy   = 0;
      m_mis    = 0;
      m_last_d = 0;
    end else if (rdy) begin
      if (m_owner_d) begin
        if (dv) q_dresp.push_back('{rd, cyc});
      end else if (iv) begin
        q_iresp.push_back('{m_iaddr[2] ? {32'd0, rd[63:32]} : {32'd0, rd[31:0]}, cyc});
      end
      q_cend.push_back(cyc + 1);
      m_busy   = 0;
      m_last_d = m_owner_d;
    end
  endtask

  task automatic idleStep(input bit rdy, input logic [63:0] rd);
    applyStimulus(0, 0, 64'd0, 0, 64'd0, 3'd0, 8'd0, 64'd0, rdy, rd);
  endtask

  // Monitor: pops an expectation whenever the DUT shows a handshake or a
  // memory bus transaction starting or ending, and checks the bus stays
  // stable while valid.
  grant_t mon_g;
  resp_t  mon_r;
  cbus_t  mon_c;
  int     mon_e;
  logic   prev_v = 1'b0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (iresp.addr_ok || dresp.addr_ok) begin
        if (q_grant.size() == 0) begin
          checkOutput("grant_unexpected", {62'd0, iresp.addr_ok, dresp.addr_ok}, 64'd0);
        end else begin
          mon_g = q_grant.pop_front();
          checkOutput("grant_port", {62'd0, iresp.addr_ok, dresp.addr_ok}, (mon_g.port == 1) ? 64'd1 : 64'd2);
          checkOutput("grant_cycle", cyc, mon_g.cyc);
        end
      end

      if (iresp.data_ok) begin
        if (q_iresp.size() == 0) begin
          checkOutput("idata_ok_unexpected", 64'd1, 64'd0);
        end else begin
          mon_r = q_iresp.pop_front();
          checkOutput("idata", {32'd0, iresp.data}, mon_r.data);
          checkOutput("idata_cycle", cyc, mon_r.cyc);
        end
      end

      if (dresp.data_ok) begin
        if (q_dresp.size() == 0) begin
          checkOutput("ddata_ok_unexpected", 64'd1, 64'd0);
        end else begin
          mon_r = q_dresp.pop_front();
          checkOutput("ddata", dresp.data, mon_r.data);
          checkOutput("ddata_cycle", cyc, mon_r.cyc);
        end
      end

      if (creq.valid && !prev_v) begin
        if (q_cbus.size() == 0) begin
          checkOutput("creq_unexpected", 64'd1, 64'd0);
        end else begin
          mon_c = q_cbus.pop_front();
          checkOutput("creq_start_cycle", cyc, mon_c.cyc);
        end
      end
      if (creq.valid) begin
        checkOutput("creq_addr", creq.addr, mon_c.addr);
        checkOutput("creq_ctrl", {50'd0, creq.is_write, creq.size, creq.strobe},
                    {50'd0, mon_c.is_write, mon_c.size, mon_c.strobe});
        checkOutput("creq_data", creq.data, mon_c.data);
      end
      if (!creq.valid && prev_v) begin
        if (q_cend.size() == 0) begin
          checkOutput("creq_drop_unexpected", 64'd1, 64'd0);
        end else begin
          mon_e = q_cend.pop_front();
          checkOutput("creq_drop_cycle", cyc, mon_e);
        end
      end
      prev_v = creq.valid;
    end
  end

  bit          r_rst, r_iv, r_dv, r_rdy;
  logic [63:0] r_ia, r_da, r_dd, r_rd;
  logic [2:0]  r_ds;
  logic [7:0]  r_dst;

  initial begin
    reset = 1'b1;
    ireq  = '0;
    dreq  = '0;
    cresp = '0;

    repeat (3) applyStimulus(1, 0, 64'd0, 0, 64'd0, 3'd0, 8'd0, 64'd0, 0, 64'd0);

    // Idle after reset, with stray memory ready that must be ignored.
    for (int k = 0; k < 10; k++) begin
      idleStep(k[0], 64'hDEAD_BEEF_0000_0000 + 64'(k));
      @(negedge clk);
      checkOutput("idle_creq_valid", {63'd0, creq.valid}, 64'd0);
      checkOutput("idle_creq_addr", creq.addr, 64'd0);
      checkOutput("idle_iresp", {30'd0, iresp}, 64'd0);
      checkOutput("idle_dresp_hs", {62'd0, dresp.addr_ok, dresp.data_ok}, 64'd0);
      checkOutput("idle_dresp_data", dresp.data, 64'd0);
    end

    // Aligned fetch from the upper half of a doubleword, memory answers 3 cycles later.
    applyStimulus(0, 1, 64'h8000_0004, 0, 64'd0, 3'd0, 8'd0, 64'd0, 0, 64'd0);
    @(negedge clk);
    checkOutput("fetch_addr_ok", {63'd0, iresp.addr_ok}, 64'd1);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 1, 64'h8000_0004, 0, 64'd0, 3'd0, 8'd0, 64'd0, 0, 64'd0);
      @(negedge clk);
      checkOutput("fetch_wait_data_ok", {63'd0, iresp.data_ok}, 64'd0);
      checkOutput("fetch_wait_creq_valid", {63'd0, creq.valid}, 64'd1);
    end
    applyStimulus(0, 1, 64'h8000_0004, 0, 64'd0, 3'd0, 8'd0, 64'd0, 1, 64'h1111_2222_3333_4444);
    @(negedge clk);
    checkOutput("fetch_data_ok", {63'd0, iresp.data_ok}, 64'd1);
    checkOutput("fetch_data", {32'd0, iresp.data}, 64'h1111_2222);
    idleStep(0, 64'd0);
    @(negedge clk);
    checkOutput("fetch_after_data_ok", {63'd0, iresp.data_ok}, 64'd0);
    checkOutput("fetch_after_creq_valid", {63'd0, creq.valid}, 64'd0);

    // Conflict right after reset: data port first, then alternation.
    applyStimulus(1, 0, 64'd0, 0, 64'd0, 3'd0, 8'd0, 64'd0, 0, 64'd0);
    applyStimulus(0, 1, 64'h100, 1, 64'h200, 3'd3, 8'h00, 64'd0, 0, 64'd0);
    @(negedge clk);
    checkOutput("conflict_d_first", {62'd0, dresp.addr_ok, iresp.addr_ok}, 64'd2);
    applyStimulus(0, 1, 64'h100, 1, 64'h200, 3'd3, 8'h00, 64'd0, 1, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    checkOutput("conflict_d_data_ok", {63'd0, dresp.data_ok}, 64'd1);
    checkOutput("conflict_d_data", dresp.data, 64'h0123_4567_89AB_CDEF);
    applyStimulus(0, 1, 64'h100, 1, 64'h200, 3'd3, 8'h00, 64'd0, 0, 64'd0);
    @(negedge clk);
    checkOutput("conflict_i_second", {62'd0, dresp.addr_ok, iresp.addr_ok}, 64'd1);
    applyStimulus(0, 1, 64'h100, 1, 64'h200, 3'd3, 8'h00, 64'd0, 1, 64'h5555_6666_7777_8888);
    @(negedge clk);
    checkOutput("conflict_i_data", {32'd0, iresp.data}, 64'h7777_8888);
    applyStimulus(0, 1, 64'h100, 1, 64'h200, 3'd3, 8'h00, 64'd0, 0, 64'd0);
    @(negedge clk);
    checkOutput("conflict_d_third", {62'd0, dresp.addr_ok, iresp.addr_ok}, 64'd2);
    idleStep(1, 64'd0);

    // Write whose requester changes fields while the bus is busy.
    applyStimulus(0, 0, 64'd0, 1, 64'h1000, 3'd3, 8'hF0, 64'hAABB_CCDD_EEFF_0011, 0, 64'd0);
    applyStimulus(0, 0, 64'd0, 1, 64'h2000, 3'd1, 8'h00, 64'd0, 0, 64'd0);
    @(negedge clk);
    checkOutput("held_addr", creq.addr, 64'h1000);
    checkOutput("held_is_write", {63'd0, creq.is_write}, 64'd1);
    checkOutput("held_size_strobe", {53'd0, creq.size, creq.strobe}, {53'd0, 3'd3, 8'hF0});
    checkOutput("held_data", creq.data, 64'hAABB_CCDD_EEFF_0011);
    applyStimulus(0, 0, 64'd0, 1, 64'h2000, 3'd1, 8'h00, 64'd0, 1, 64'd0);

    // Fetch abandoned before memory answers, then a data request is served.
    applyStimulus(0, 1, 64'h3000, 0, 64'd0, 3'd0, 8'd0, 64'd0, 0, 64'd0);
    applyStimulus(0, 0, 64'h3000, 0, 64'd0, 3'd0, 8'd0, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    checkOutput("abandon_no_data_ok", {63'd0, iresp.data_ok}, 64'd0);
    applyStimulus(0, 0, 64'd0, 1, 64'h4000, 3'd3, 8'd0, 64'd0, 0, 64'd0);
    @(negedge clk);
    checkOutput("abandon_then_idle", {63'd0, dresp.addr_ok}, 64'd1);
    applyStimulus(0, 0, 64'd0, 1, 64'h4000, 3'd3, 8'd0, 64'd0, 1, 64'h42);

    // Misaligned fetch completes with zero data without touching memory.
    applyStimulus(0, 1, 64'h5002, 0, 64'd0, 3'd0, 8'd0, 64'd0, 0, 64'd0);
    @(negedge clk);
    checkOutput("mis_addr_ok", {63'd0, iresp.addr_ok}, 64'd1);
    applyStimulus(0, 1, 64'h5002, 0, 64'd0, 3'd0, 8'd0, 64'd0, 1, 64'h9999_9999_9999_9999);
    @(negedge clk);
    checkOutput("mis_data_ok", {63'd0, iresp.data_ok}, 64'd1);
    checkOutput("mis_data", {32'd0, iresp.data}, 64'd0);
    checkOutput("mis_no_creq", {63'd0, creq.valid}, 64'd0);

    // Reset in the middle of a data transaction, followed by a late ready.
    applyStimulus(0, 0, 64'd0, 1, 64'h6000, 3'd3, 8'h0F, 64'h77, 0, 64'd0);
    applyStimulus(1, 0, 64'd0, 0, 64'd0, 3'd0, 8'd0, 64'd0, 0, 64'd0);
    applyStimulus(0, 0, 64'd0, 0, 64'd0, 3'd0, 8'd0, 64'd0, 1, 64'h1234);
    @(negedge clk);
    checkOutput("reset_no_data_ok", {63'd0, dresp.data_ok}, 64'd0);
    checkOutput("reset_creq_dropped", {63'd0, creq.valid}, 64'd0);

    // Randomized traffic, including occasional resets and stray ready.
    for (int n = 0; n < 3000; n++) begin
      r_rst = ($urandom_range(99) == 0);
      r_iv  = !r_rst && ($urandom_range(9) < 6);
      r_dv  = !r_rst && ($urandom_range(9) < 6);
      r_rdy = !r_rst && ($urandom_range(9) < 4);
      r_ia  = {$urandom, $urandom};
      if ($urandom_range(4) != 0) r_ia[1:0] = 2'b00;
      r_da  = {$urandom, $urandom};
      r_ds  = 3'($urandom_range(7));
      r_dst = ($urandom_range(1) == 0) ? 8'd0 : 8'($urandom_range(255));
      r_dd  = {$urandom, $urandom};
      r_rd  = {$urandom, $urandom};
      applyStimulus(r_rst, r_iv, r_ia, r_dv, r_da, r_ds, r_dst, r_dd, r_rdy, r_rd);
    end

    repeat (4) idleStep(1, 64'd0);
    repeat (2) idleStep(0, 64'd0);
    @(negedge clk);

    checkOutput("left_grant", q_grant.size(), 64'd0);
    checkOutput("left_iresp", q_iresp.size(), 64'd0);
    checkOutput("left_dresp", q_dresp.size(), 64'd0);
    checkOutput("left_cbus", q_cbus.size(), 64'd0);
    checkOutput("left_cend", q_cend.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
